// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the writeback/commit stage.
// Holds the MEM/WB control field layout and the ecall FSM state encoding.
package pipeline_pkg;

    localparam int XLEN          = 64;
    localparam int REG_ADDR_W    = 5;
    localparam int ECALL_RET_REG = 10;
    localparam int CNT_W         = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic is_ecall;
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

endpackage

// File: rtl/wb_ecall_fsm.sv
// Ecall handshake: IDLE -> REQ (until ack) -> WB (one cycle), latching the handler return value.
// Stall is raised combinationally on ecall detect and held through REQ; WB releases upstream.
module wb_ecall_fsm #(
    parameter int XLEN = pipeline_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_in_valid,
    input  logic            i_is_ecall,
    input  logic            i_ecall_ack,
    input  logic [XLEN-1:0] i_ecall_ret,
    output logic            o_ecall_req,
    output logic            o_stall,
    output logic            o_idle,
    output logic            o_wb,
    output logic [XLEN-1:0] o_ret_q
);
    import pipeline_pkg::*;

    wb_state_e       r_state;
    wb_state_e       w_state_nxt;
    logic [XLEN-1:0] r_ret_q;
    logic            w_req;
    logic            w_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ret_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == REQ && i_ecall_ack) begin
                r_ret_q <= i_ecall_ret;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_in_valid && i_is_ecall) begin
                    w_stall     = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
                if (i_ecall_ack) begin
                    w_state_nxt = WB;
                end
            end
            WB: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The IDLE-state stall depends on live inputs, so it is masked while reset is held.
    assign o_ecall_req = w_req & reset;
    assign o_stall     = w_stall & reset;
    assign o_idle      = (r_state == IDLE);
    assign o_wb        = (r_state == WB);
    assign o_ret_q     = r_ret_q;

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit: same-cycle register-file write for normal instructions, retire counter, ecall handshake.
// Ecall stalls upstream until ack; the a0 write lands one cycle after ack, min 3 cycles end to end.
module wb_commit #(
    parameter int XLEN          = pipeline_pkg::XLEN,
    parameter int REG_ADDR_W    = pipeline_pkg::REG_ADDR_W,
    parameter int ECALL_RET_REG = pipeline_pkg::ECALL_RET_REG,
    parameter int CNT_W         = pipeline_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  reg_write_in,
    input  logic                  mem_to_reg_in,
    input  logic                  is_ecall_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic [XLEN-1:0]       alu_result_in,
    input  logic [XLEN-1:0]       mem_data_in,
    output logic                  ecall_req,
    input  logic                  ecall_ack,
    input  logic [XLEN-1:0]       ecall_ret,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  stall_out,
    output logic [CNT_W-1:0]      retire_count
);
    import pipeline_pkg::*;

    wb_ctrl_t        w_ctrl;
    logic            w_idle;
    logic            w_wb;
    logic            w_norm;
    logic [XLEN-1:0] w_ret_q;
    logic [CNT_W-1:0] r_retire_count;

    assign w_ctrl = '{is_ecall: is_ecall_in, reg_write: reg_write_in, mem_to_reg: mem_to_reg_in};

    wb_ecall_fsm #(
        .XLEN (XLEN)
    ) u_ecall_fsm (
        .clk         (clk),
        .reset       (reset),
        .i_in_valid  (in_valid),
        .i_is_ecall  (w_ctrl.is_ecall),
        .i_ecall_ack (ecall_ack),
        .i_ecall_ret (ecall_ret),
        .o_ecall_req (ecall_req),
        .o_stall     (stall_out),
        .o_idle      (w_idle),
        .o_wb        (w_wb),
        .o_ret_q     (w_ret_q)
    );

    // A normal instruction retires only from IDLE; the stale ecall seen during WB is not one.
    assign w_norm = w_idle & in_valid & ~w_ctrl.is_ecall;

    assign rf_we    = reset & (w_wb | (w_norm & w_ctrl.reg_write & (rd_in != '0)));
    assign rf_waddr = w_wb ? REG_ADDR_W'(ECALL_RET_REG) : rd_in;
    assign rf_wdata = w_wb ? w_ret_q : (w_ctrl.mem_to_reg ? alu_result_in : mem_data_in);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retire_count <= '0;
        end else if (w_norm || w_wb) begin
            r_retire_count <= r_retire_count + CNT_W'(1);
        end
    end

    assign retire_count = r_retire_count;

endmodule

// File: tb/tb_wb_commit.sv
// Directed plus randomized bench for wb_commit; expectations come from the instruction-level rules.
module tb_wb_commit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        reg_write_in;
    logic        mem_to_reg_in;
    logic        is_ecall_in;
    logic [4:0]  rd_in;
    logic [63:0] alu_result_in;
    logic [63:0] mem_data_in;
    logic        ecall_req;
    logic        ecall_ack;
    logic [63:0] ecall_ret;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        stall_out;
    logic [63:0] retire_count;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_cnt = 64'd0;

    always #5 clk = ~clk;

    wb_commit dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .reg_write_in  (reg_write_in),
        .mem_to_reg_in (mem_to_reg_in),
        .is_ecall_in   (is_ecall_in),
        .rd_in         (rd_in),
        .alu_result_in (alu_result_in),
        .mem_data_in   (mem_data_in),
        .ecall_req     (ecall_req),
        .ecall_ack     (ecall_ack),
        .ecall_ret     (ecall_ret),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .stall_out     (stall_out),
        .retire_count  (retire_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic e, input logic rw, input logic m2r,
                          input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] mem);
        in_valid      = v;
        is_ecall_in   = e;
        reg_write_in  = rw;
        mem_to_reg_in = m2r;
        rd_in         = rd;
        alu_result_in = alu;
        mem_data_in   = mem;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // One non-ecall slot presented in IDLE: checks the same-cycle write and the count after the edge.
    task automatic cyc_normal(input string tag, input logic v, input logic rw, input logic m2r,
                              input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] mem);
        logic exp_we;
        set_in(v, 1'b0, rw, m2r, rd, alu, mem);
        exp_we = v && rw && (rd != 5'd0);
        @(negedge clk);
        chk({tag, "_we"}, 64'(rf_we), 64'(exp_we));
        if (exp_we) begin
            chk({tag, "_waddr"}, 64'(rf_waddr), 64'(rd));
            chk({tag, "_wdata"}, rf_wdata, m2r ? alu : mem);
        end
        chk({tag, "_stall"}, 64'(stall_out), 64'd0);
        chk({tag, "_req"}, 64'(ecall_req), 64'd0);
        @(posedge clk); #1;
        if (v) exp_cnt = exp_cnt + 64'd1;
        chk({tag, "_cnt"}, retire_count, exp_cnt);
    endtask

    // Ecall with ack arriving in the d-th request cycle; the a0 write is expected the cycle after.
    task automatic do_ecall(input string tag, input int d, input logic [63:0] ret);
        set_in(1'b1, 1'b1, 1'($urandom()), 1'($urandom()), 5'($urandom()), rnd64(), rnd64());
        ecall_ack = 1'b0;
        @(negedge clk);
        chk({tag, "_det_stall"}, 64'(stall_out), 64'd1);
        chk({tag, "_det_req"}, 64'(ecall_req), 64'd0);
        chk({tag, "_det_we"}, 64'(rf_we), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < d; i++) begin
            ecall_ack = (i == d - 1);
            ecall_ret = (i == d - 1) ? ret : rnd64();
            @(negedge clk);
            chk({tag, "_req"}, 64'(ecall_req), 64'd1);
            chk({tag, "_req_stall"}, 64'(stall_out), 64'd1);
            chk({tag, "_req_we"}, 64'(rf_we), 64'd0);
            chk({tag, "_req_cnt"}, retire_count, exp_cnt);
            @(posedge clk); #1;
        end
        ecall_ack = 1'b0;
        ecall_ret = rnd64();
        @(negedge clk);
        chk({tag, "_wb_we"}, 64'(rf_we), 64'd1);
        chk({tag, "_wb_waddr"}, 64'(rf_waddr), 64'd10);
        chk({tag, "_wb_wdata"}, rf_wdata, ret);
        chk({tag, "_wb_stall"}, 64'(stall_out), 64'd0);
        chk({tag, "_wb_req"}, 64'(ecall_req), 64'd0);
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 64'd1;
        chk({tag, "_wb_cnt"}, retire_count, exp_cnt);
    endtask

    initial begin
        reset     = 1'b0;
        ecall_ack = 1'b0;
        ecall_ret = 64'd0;
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 64'h55, 64'h66);

        // Reset holds writes, stall and count low even with live inputs.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_cnt", retire_count, 64'd0);
        chk("rst_req", 64'(ecall_req), 64'd0);
        is_ecall_in = 1'b1;
        #1;
        chk("rst_stall_ecall", 64'(stall_out), 64'd0);
        is_ecall_in = 1'b0;

        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rel_we", 64'(rf_we), 64'd1);
        chk("rel_waddr", 64'(rf_waddr), 64'd5);
        @(posedge clk); #1;
        exp_cnt = 64'd1;
        chk("rel_cnt", retire_count, exp_cnt);

        cyc_normal("alu", 1'b1, 1'b1, 1'b1, 5'd7, 64'h1234, 64'hBEEF);
        cyc_normal("load", 1'b1, 1'b1, 1'b0, 5'd7, 64'h1234, 64'hBEEF);
        cyc_normal("x0", 1'b1, 1'b1, 1'b1, 5'd0, 64'h77, 64'h88);
        cyc_normal("bubble", 1'b0, 1'b1, 1'b1, 5'd9, 64'h77, 64'h88);
        cyc_normal("nowr", 1'b1, 1'b0, 1'b1, 5'd9, 64'h77, 64'h88);

        do_ecall("ecall4", 4, 64'h2A);
        do_ecall("ecall1", 1, 64'hDEAD_BEEF_0000_0001);
        cyc_normal("after_ecall", 1'b1, 1'b1, 1'b1, 5'd3, 64'h3333, 64'h4444);
        chk("after_ecall_notx10", 64'(rf_waddr), 64'd3);

        // Reset pulse while a request is outstanding.
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 64'h0, 64'h0);
        @(negedge clk);
        chk("abort_det_stall", 64'(stall_out), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_req_before", 64'(ecall_req), 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("abort_req", 64'(ecall_req), 64'd0);
        chk("abort_stall", 64'(stall_out), 64'd0);
        chk("abort_we", 64'(rf_we), 64'd0);
        chk("abort_cnt", retire_count, 64'd0);
        exp_cnt = 64'd0;
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 64'h0, 64'h0);
        @(posedge clk); #1;
        reset     = 1'b1;
        ecall_ack = 1'b1;
        ecall_ret = 64'h99;
        @(negedge clk);
        chk("stray_we", 64'(rf_we), 64'd0);
        chk("stray_req", 64'(ecall_req), 64'd0);
        chk("stray_stall", 64'(stall_out), 64'd0);
        @(posedge clk); #1;
        ecall_ack = 1'b0;
        @(negedge clk);
        chk("stray_next_we", 64'(rf_we), 64'd0);
        chk("stray_next_req", 64'(ecall_req), 64'd0);
        chk("stray_cnt", retire_count, exp_cnt);
        @(posedge clk); #1;

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_ecall("rnd_ecall", int'($urandom_range(1, 5)), rnd64());
            end else begin
                cyc_normal("rnd", ($urandom_range(0, 3) != 0), 1'($urandom()), 1'($urandom()),
                           5'($urandom()), rnd64(), rnd64());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
- Writeback/commit stage consuming the MEM/WB pipeline register's control and data outputs (reg_write, mem_to_reg, is_ecall, rd, ALU result, load data).
- Drives the register file write port and the forwarding tap, and counts retired instructions.
- Runs the ecall handshake with the environment/syscall handler, stalling upstream until the handler returns a value for x10.

Parameters:
XLEN, 64, datapath width
REG_ADDR_W, 5, register index width
ECALL_RET_REG, 10, register written with the ecall return value (a0)
CNT_W, 64, retired-instruction counter width

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  MEM/WB slot holds a real instruction (0 = bubble)
reg_write_in  in  1  write back to register file
mem_to_reg_in  in  1  writeback source: 0 = memory data, 1 = ALU result
is_ecall_in  in  1  instruction is ecall
rd_in  in  REG_ADDR_W  destination register
alu_result_in  in  XLEN  ALU result
mem_data_in  in  XLEN  load data
ecall_req  out  1  request to syscall handler
ecall_ack  in  1  handler done; ecall_ret valid this cycle
ecall_ret  in  XLEN  handler return value
rf_we  out  1  register file write enable
rf_waddr  out  REG_ADDR_W  register file write address
rf_wdata  out  XLEN  register file write data
stall_out  out  1  hold all upstream pipeline registers
retire_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset (reset=0, async): state=IDLE, ret_q=0, retire_count=0. While in reset: ecall_req=0, rf_we=0, stall_out=0.
- FSM states: IDLE, REQ, WB.
- IDLE, normal instruction (in_valid=1, is_ecall_in=0):
  - Combinational writeback, same cycle.
  - rf_we = reg_write_in && rd_in!=0.
  - rf_waddr = rd_in.
  - rf_wdata = mem_to_reg_in ? alu_result_in : mem_data_in.
  - retire_count += 1 at the posedge, including reg_write_in=0 instructions and rd_in=0 writes.
- IDLE, ecall (in_valid=1, is_ecall_in=1):
  - rf_we=0.
  - stall_out=1 combinationally.
  - Next state REQ.
- IDLE, bubble (in_valid=0): no write, no count. reg_write_in is ignored when in_valid=0.
- REQ:
  - ecall_req=1, stall_out=1, rf_we=0.
  - Stays in REQ until ecall_ack=1. On ack: ret_q <= ecall_ret, next state WB.
  - ecall_ack while in IDLE or WB is ignored.
- WB (exactly one cycle):
  - rf_we=1, rf_waddr=ECALL_RET_REG, rf_wdata=ret_q.
  - stall_out=0, so the upstream register advances at the end of this cycle.
  - The stale ecall still on the inputs this cycle is ignored.
  - retire_count += 1. Next state IDLE.
- Ecall latency: ecall in IDLE to req high is 1 cycle. Ack to x10 write is 1 cycle. Minimum total is 3 cycles when ack arrives in the first REQ cycle.
- ecall_req and stall_out are pure functions of state and inputs; no glitch filtering.
- retire_count wraps modulo 2^CNT_W, with no saturation.
- Reset asserted in REQ or WB: abort immediately and return to IDLE. The pending x10 write is lost and ecall_req drops asynchronously.
- mem_to_reg_in and rd_in are ignored for ecalls.

Decomposition:
- Shared package pipeline_pkg holds:
  - typedef wb_state_e {IDLE, REQ, WB}
  - localparam ECALL_RET_REG
  - XLEN and REG_ADDR_W constants
  - packed struct wb_ctrl_t {is_ecall, reg_write, mem_to_reg}, matching the MEM/WB control register fields
- One natural sub-module: wb_ecall_fsm. It owns the state, ret_q, ecall_req and stall_out. The top level owns the writeback mux, x0 suppression and retire_count.

Test Plan:
- Reset: hold reset=0 with in_valid=1 ALU write to x5 -> rf_we=0, retire_count=0. Release -> rf_we=1, rf_waddr=5 same cycle.
- ALU vs load: rd=7, alu=0x1234, mem=0xBEEF, mem_to_reg=1 -> rf_wdata=0x1234. Set mem_to_reg=0 -> rf_wdata=0xBEEF. retire_count increments by 2.
- x0 and bubble: rd=0 reg_write=1 -> rf_we=0, count +1. in_valid=0 reg_write=1 -> rf_we=0, count unchanged.
- Ecall with ack after 4 REQ cycles, ecall_ret=0x2A:
  - stall_out=1 for the detect cycle plus 4 REQ cycles, and ecall_req=1 for exactly those 4 cycles.
  - Next cycle: rf_we=1, rf_waddr=10, rf_wdata=0x2A, stall_out=0, count +1.
- Ecall with ack in the first REQ cycle -> WB on cycle 3. A following ALU write to x3 presented the cycle after WB -> written normally, no double write of x10.
- Reset pulse during REQ -> ecall_req=0 immediately, state IDLE, no x10 write. A stray ecall_ack in IDLE -> no write, no state change.
